// File: rtl/bool_op_arbiter.sv
// Two-requester boolean operation unit with round-robin tie break.
// IDLE grants, EXEC evaluates, RESP holds the result until accepted.
module bool_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [1:0]       req0_op_i,
    input  logic [1:0]       req1_op_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_data_o,
    output logic             res_id_o,
    output logic             res_err_o,
    output logic             busy_o,
    output logic [15:0]      op_count_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             data_q, data_d;
    logic             rid_q, rid_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             gnt_any;
    logic             gnt_id;
    logic             a_nz;
    logic             b_nz;

    // Grant: single valid wins outright, a tie goes to the pointer.
    always_comb begin
        gnt_any = |req_valid_i;
        gnt_id  = (&req_valid_i) ? ptr_q : req_valid_i[1];
        req_ready_o = 2'b00;
        if (state_q == IDLE && gnt_any) begin
            req_ready_o = gnt_id ? 2'b10 : 2'b01;
        end
    end

    assign a_nz = |a_q;
    assign b_nz = |b_q;

    // Next-state, capture, evaluation and completion bookkeeping.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        rid_d   = rid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d     = gnt_id ? req1_a_i  : req0_a_i;
                    b_d     = gnt_id ? req1_b_i  : req0_b_i;
                    op_d    = gnt_id ? req1_op_i : req0_op_i;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rid_d = id_q;
                err_d = 1'b0;
                case (op_q)
                    OP_AND:  data_d = a_nz & b_nz;
                    OP_OR:   data_d = a_nz | b_nz;
                    OP_NOT:  data_d = ~a_nz;
                    default: begin
                        data_d = 1'b0;
                        err_d  = 1'b1;
                    end
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (res_ready_i) begin
                    ptr_d   = ~rid_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            id_q    <= 1'b0;
            data_q  <= 1'b0;
            rid_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid_o = (state_q == RESP);
    assign res_data_o  = data_q;
    assign res_id_o    = rid_q;
    assign res_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);
    assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_bool_op_arbiter.sv
// Directed bench for bool_op_arbiter.
// Expected values are hand-computed per vector.
module tb_bool_op_arbiter;

    logic        clk;
    logic        rst_ni;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready_o;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic        res_valid_o;
    logic        res_ready;
    logic        res_data_o;
    logic        res_id_o;
    logic        res_err_o;
    logic        busy_o;
    logic [15:0] op_count_o;

    int          n_chk;
    int          n_err;
    logic [15:0] exp_cnt;

    bool_op_arbiter #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req0_a_i    (a0),
        .req0_b_i    (b0),
        .req1_a_i    (a1),
        .req1_b_i    (b1),
        .req0_op_i   (op0),
        .req1_op_i   (op1),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready),
        .res_data_o  (res_data_o),
        .res_id_o    (res_id_o),
        .res_err_o   (res_err_o),
        .busy_o      (busy_o),
        .op_count_o  (op_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; runs one full operation with res_ready=1.
    task automatic do_op(input logic id, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op,
                         input logic ed, input logic ee);
        if (id) begin
            a1 = a; b1 = b; op1 = op;
        end else begin
            a0 = a; b0 = b; op0 = op;
        end
        req_valid = id ? 2'b10 : 2'b01;
        res_ready = 1'b1;
        #1;
        chk("grant", {30'd0, req_ready_o}, id ? 32'd2 : 32'd1);
        chk("idle_vld", {31'd0, res_valid_o}, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        chk("exec_busy", {31'd0, busy_o}, 32'd1);
        chk("exec_vld", {31'd0, res_valid_o}, 32'd0);
        chk("exec_rdy", {30'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("resp_vld", {31'd0, res_valid_o}, 32'd1);
        chk("resp_data", {31'd0, res_data_o}, {31'd0, ed});
        chk("resp_id", {31'd0, res_id_o}, {31'd0, id});
        chk("resp_err", {31'd0, res_err_o}, {31'd0, ee});
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("done_busy", {31'd0, busy_o}, 32'd0);
        chk("done_cnt", {16'd0, op_count_o}, {16'd0, exp_cnt});
        chk("hold_data", {31'd0, res_data_o}, {31'd0, ed});
        chk("hold_id", {31'd0, res_id_o}, {31'd0, id});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_cnt = 16'd0;
        rst_ni = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b0;
        a0 = 8'h00; b0 = 8'h00; op0 = 2'b00;
        a1 = 8'h00; b1 = 8'h00; op1 = 2'b00;
        #2;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_vld", {31'd0, res_valid_o}, 32'd0);
        chk("rst_cnt", {16'd0, op_count_o}, 32'd0);
        chk("rst_data", {31'd0, res_data_o}, 32'd0);
        chk("rst_err", {31'd0, res_err_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        do_op(1'b0, 8'h3D, 8'hA6, 2'b00, 1'b1, 1'b0);
        do_op(1'b1, 8'h3D, 8'h00, 2'b10, 1'b0, 1'b0);
        do_op(1'b1, 8'h00, 8'h00, 2'b10, 1'b1, 1'b0);
        do_op(1'b0, 8'h00, 8'h05, 2'b01, 1'b1, 1'b0);
        do_op(1'b1, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0);
        do_op(1'b0, 8'h3D, 8'h00, 2'b00, 1'b0, 1'b0);
        do_op(1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0, 1'b1);

        // Backpressure: result must hold while res_ready is low.
        a0 = 8'h10; b0 = 8'h00; op0 = 2'b01;
        req_valid = 2'b01;
        res_ready = 1'b0;
        #1;
        chk("bp_grant", {30'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", {31'd0, res_valid_o}, 32'd1);
            chk("bp_data", {31'd0, res_data_o}, 32'd1);
            chk("bp_id", {31'd0, res_id_o}, 32'd0);
            chk("bp_err", {31'd0, res_err_o}, 32'd0);
            chk("bp_busy", {31'd0, busy_o}, 32'd1);
            chk("bp_rdy", {30'd0, req_ready_o}, 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_idle", {31'd0, busy_o}, 32'd0);
        chk("bp_cnt", {16'd0, op_count_o}, {16'd0, exp_cnt});

        // Reset in EXEC drops the operation.
        a0 = 8'h01; b0 = 8'h01; op0 = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_vld", {31'd0, res_valid_o}, 32'd0);
        chk("mid_rst_cnt", {16'd0, op_count_o}, 32'd0);
        chk("mid_rst_err", {31'd0, res_err_o}, 32'd0);
        chk("mid_rst_id", {31'd0, res_id_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("post_rst_vld", {31'd0, res_valid_o}, 32'd0);
        chk("post_rst_cnt", {16'd0, op_count_o}, 32'd0);

        // Both valid continuously: grants alternate from 0.
        a0 = 8'h01; b0 = 8'h01; op0 = 2'b00;
        a1 = 8'h00; b1 = 8'h00; op1 = 2'b10;
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_grant", {30'd0, req_ready_o},
                (i % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
            @(negedge clk);
            chk("alt_id", {31'd0, res_id_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_data", {31'd0, res_data_o}, 32'd1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        exp_cnt = 16'd4;
        #1;
        chk("alt_cnt", {16'd0, op_count_o}, {16'd0, exp_cnt});

        // Counter wrap.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        chk("wrap_pre", {16'd0, op_count_o}, 32'h0000FFFF);
        @(negedge clk);
        do_op(1'b1, 8'h07, 8'h00, 2'b01, 1'b1, 1'b0);
        chk("wrap_zero", {16'd0, op_count_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bool_op_arbiter.md
BOOL_OP_ARBITER -- requirements
Module: bool_op_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (WIDTH >= 1).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req_valid_i[1:0]  input  2  per-requester request valid.
REQ-005 SHALL have ports req_ready_o[1:0]  output  2  per-requester request accepted this cycle.
REQ-006 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  WIDTH each  operands A/B.
REQ-007 SHALL have ports req0_op_i, req1_op_i  input  2 each  opcode: 00 logical AND, 01 logical OR, 10 logical NOT of A, 11 reserved.
REQ-008 SHALL have port res_valid_o  output  1  result valid.
REQ-009 SHALL have port res_ready_i  input  1  consumer accepts result.
REQ-010 SHALL have port res_data_o  output  1  boolean result.
REQ-011 SHALL have port res_id_o  output  1  index of requester owning result.
REQ-012 SHALL have port res_err_o  output  1  reserved opcode flag.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port op_count_o  output  16  completed-result counter.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, SHALL grant one requester with valid high; if both are valid, grant the one indicated by the 1-bit priority pointer.
REQ-017 req_ready_o[g] SHALL be high only in IDLE, combinationally, for granted requester g; the other bit SHALL be low; both SHALL be low in EXEC and RESP.
REQ-018 On transfer (valid & ready), SHALL capture the granted A, B, op and id into internal registers and enter EXEC next cycle.
REQ-019 In EXEC, SHALL compute: AND -> (A!=0)&&(B!=0); OR -> (A!=0)||(B!=0); NOT -> (A==0); reserved -> data 0, err 1; non-reserved -> err 0. SHALL register data/id/err and enter RESP.
REQ-020 In RESP, res_valid_o SHALL be 1 and res_data_o/res_id_o/res_err_o SHALL hold stable until res_ready_i is high.
REQ-021 On res_valid_o & res_ready_i, SHALL return to IDLE next cycle, set the priority pointer to the requester not just served, and increment op_count_o by 1.
REQ-022 Latency SHALL be: transfer in cycle N -> res_valid_o high in cycle N+2; minimum 3 cycles per operation.
REQ-023 op_count_o SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-024 Requests arriving outside IDLE SHALL wait; requester inputs SHALL be ignored except at transfer.
REQ-025 Reserved-opcode results SHALL count in op_count_o like any other result.
REQ-026 res_data_o, res_id_o and res_err_o SHALL keep their last values after leaving RESP until the next EXEC.

Reset
REQ-027 On rst_ni low, SHALL immediately force: state IDLE, pointer 0, res_valid_o 0, res_data_o 0, res_id_o 0, res_err_o 0, busy_o 0, op_count_o 0, captured operands 0.
REQ-028 Reset mid-operation (EXEC or RESP) SHALL drop the in-flight operation with no result and no count increment.
REQ-029 After rst_ni rises, the first grant SHALL be possible on the first rising edge.

Verification
REQ-030 Req0 AND, A=0x3D, B=0xA6, res_ready_i=1 -> res_valid_o at N+2, data 1, id 0, err 0, op_count_o 1.
REQ-031 Req1 NOT, A=0x3D -> data 0, id 1; then A=0x00 -> data 1.
REQ-032 Both valid continuously after reset, res_ready_i=1 -> grants alternate 0,1,0,1; res_id_o sequence 0,1,0,1.
REQ-033 res_ready_i held 0 for 5 cycles in RESP -> res_valid_o and outputs stable, both req_ready_o low, busy_o 1; release -> IDLE next cycle.
REQ-034 Op 11 from req0 -> data 0, err 1, count increments; rst_ni pulsed low in EXEC -> all outputs at reset values, no result emitted.
REQ-035 Preload 0xFFFF completions (or force) then one more -> op_count_o 0x0000.
